// File: rtl/miner_dispatch_if.sv
// miner_dispatch_if: host and worker-lane bus of the nonce dispatcher
interface miner_dispatch_if #(
  parameter int LANES = 4
);
  logic              start;
  logic              abort;
  logic [31:0]       nonce_start;
  logic [31:0]       nonce_end;
  logic              busy;
  logic              done;
  logic [LANES-1:0]  lane_valid;
  logic [32*LANES-1:0] lane_nonce;
  logic [LANES-1:0]  res_valid;
  logic [LANES-1:0]  res_hit;
  logic              found_valid;
  logic [31:0]       found_nonce;
  logic              found_ready;
  logic              found_overflow;
  logic              err_spurious;
  logic [47:0]       hash_count;
  modport master (
    output start, abort, nonce_start, nonce_end, res_valid, res_hit, found_ready,
    input  busy, done, lane_valid, lane_nonce, found_valid, found_nonce,
           found_overflow, err_spurious, hash_count
  );
  modport slave (
    input  start, abort, nonce_start, nonce_end, res_valid, res_hit, found_ready,
    output busy, done, lane_valid, lane_nonce, found_valid, found_nonce,
           found_overflow, err_spurious, hash_count
  );
endinterface

// File: rtl/miner_dispatch.sv
// miner_dispatch: issues nonce rounds to worker lanes, matches results to nonces, queues winners
module miner_dispatch #(
  parameter int LANES          = 4,
  parameter int ISSUE_INTERVAL = 1000,
  parameter int INFLIGHT       = 8,
  parameter int FOUND_DEPTH    = 4
) (
  input logic clk,
  input logic reset,
  miner_dispatch_if.slave bus
);
  localparam int CW = $clog2(ISSUE_INTERVAL);
  localparam int IW = INFLIGHT > 1 ? $clog2(INFLIGHT) : 1;
  localparam int FW = FOUND_DEPTH > 1 ? $clog2(FOUND_DEPTH) : 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int PW = $clog2(LANES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(ISSUE_INTERVAL - 1);
  localparam logic [IW:0]   TAG_FULL   = (IW+1)'(INFLIGHT);
  localparam logic [FW:0]   FOUND_FULL = (FW+1)'(FOUND_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q;
  logic [32:0]         next_q;
  logic [32:0]         end_q;
  logic [CW-1:0]       cnt_q;
  logic [LANES-1:0]    lane_valid_q;
  logic [32*LANES-1:0] lane_nonce_q;
  logic [31:0]         tag_mem_q [LANES][INFLIGHT];
  logic [IW-1:0]       tag_wr_q [LANES];
  logic [IW-1:0]       tag_rd_q [LANES];
  logic [IW:0]         tag_cnt_q [LANES];
  logic [LANES-1:0]    hold_v_q;
  logic [31:0]         hold_n_q [LANES];
  logic [31:0]         found_mem_q [FOUND_DEPTH];
  logic [FW-1:0]       found_wr_q;
  logic [FW-1:0]       found_rd_q;
  logic [FW:0]         found_cnt_q;
  logic                found_overflow_q;
  logic                err_spurious_q;
  logic                done_q;
  logic [47:0]         hash_q;

  logic             start_acc;
  logic             round_try;
  logic             last_round;
  logic             stall;
  logic             issue;
  logic             tags_empty;
  logic             fpop;
  logic             xfer;
  logic             hit_drop;
  logic [32:0]      base;
  logic [32:0]      lim;
  logic [LANES-1:0] want;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop;
  logic [LANES-1:0] spur;
  logic [LANES-1:0] hit_load;
  logic [LW-1:0]    xfer_idx;
  logic [31:0]      xfer_n;
  logic [PW-1:0]    n_pop;
  logic [48:0]      hash_d;

  function automatic logic [IW-1:0] tag_inc(input logic [IW-1:0] p);
    return p == IW'(INFLIGHT - 1) ? '0 : p + IW'(1);
  endfunction

  function automatic logic [FW-1:0] found_inc(input logic [FW-1:0] p);
    return p == FW'(FOUND_DEPTH - 1) ? '0 : p + FW'(1);
  endfunction

  // Round issue decision, result matching and hold-to-FIFO arbitration; start issues its first round immediately
  always_comb begin
    start_acc  = state_q == IDLE && bus.start;
    base       = start_acc ? {1'b0, bus.nonce_start} : next_q;
    lim        = start_acc ? {1'b0, bus.nonce_end} : end_q;
    round_try  = start_acc ? bus.nonce_end >= bus.nonce_start
                           : state_q == RUN && cnt_q == '0 && !bus.abort;
    last_round = base + 33'(LANES) > lim;
    stall      = 1'b0;
    tags_empty = 1'b1;
    n_pop      = '0;
    xfer_idx   = '0;
    for (int l = 0; l < LANES; l++) begin
      pop[l]      = bus.res_valid[l] && tag_cnt_q[l] != '0;
      spur[l]     = bus.res_valid[l] && tag_cnt_q[l] == '0;
      want[l]     = round_try && base + 33'(l) <= lim;
      hit_load[l] = pop[l] && bus.res_hit[l] && !hold_v_q[l];
      stall       = stall || (want[l] && tag_cnt_q[l] == TAG_FULL && !pop[l]);
      tags_empty  = tags_empty && tag_cnt_q[l] == '0;
      n_pop       = n_pop + PW'(pop[l]);
    end
    for (int l = LANES - 1; l >= 0; l--)
      xfer_idx = hold_v_q[l] ? LW'(l) : xfer_idx;
    issue    = round_try && !stall;
    push     = issue ? want : '0;
    hit_drop = |(pop & bus.res_hit & hold_v_q);
    fpop     = found_cnt_q != '0 && bus.found_ready;
    xfer     = hold_v_q != '0 && (found_cnt_q != FOUND_FULL || fpop);
    xfer_n   = hold_n_q[xfer_idx];
    hash_d   = {1'b0, hash_q} + 49'(n_pop);
  end

  // Control FSM, issue counter, FIFO pointers, hold registers and status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= IDLE;
      next_q           <= '0;
      end_q            <= '0;
      cnt_q            <= '0;
      lane_valid_q     <= '0;
      lane_nonce_q     <= '0;
      hold_v_q         <= '0;
      found_wr_q       <= '0;
      found_rd_q       <= '0;
      found_cnt_q      <= '0;
      found_overflow_q <= 1'b0;
      err_spurious_q   <= 1'b0;
      done_q           <= 1'b0;
      hash_q           <= '0;
      for (int l = 0; l < LANES; l++) begin
        tag_wr_q[l]  <= '0;
        tag_rd_q[l]  <= '0;
        tag_cnt_q[l] <= '0;
        hold_n_q[l]  <= '0;
      end
    end else begin
      done_q       <= 1'b0;
      lane_valid_q <= push;
      if (start_acc) begin
        next_q <= base;
        end_q  <= lim;
        cnt_q  <= '0;
      end
      if (issue) begin
        next_q <= base + 33'(LANES);
        cnt_q  <= CW'(1);
      end else if (state_q == RUN && cnt_q != '0) begin
        cnt_q <= cnt_q == CNT_MAX ? '0 : cnt_q + CW'(1);
      end
      case (state_q)
        IDLE:    if (bus.start) state_q <= (!round_try || (issue && last_round)) ? DRAIN : RUN;
        RUN:     if (bus.abort || (issue && last_round)) state_q <= DRAIN;
        DRAIN:   if (tags_empty && hold_v_q == '0) begin
                   state_q <= IDLE;
                   done_q  <= 1'b1;
                 end
        default: state_q <= IDLE;
      endcase
      for (int l = 0; l < LANES; l++) begin
        if (push[l]) begin
          lane_nonce_q[32*l +: 32] <= base[31:0] + 32'(l);
          tag_wr_q[l]              <= tag_inc(tag_wr_q[l]);
        end
        if (pop[l]) tag_rd_q[l] <= tag_inc(tag_rd_q[l]);
        tag_cnt_q[l] <= tag_cnt_q[l] + (IW+1)'(push[l]) - (IW+1)'(pop[l]);
        if (hit_load[l]) hold_n_q[l] <= tag_mem_q[l][tag_rd_q[l]];
        hold_v_q[l] <= hit_load[l] || (hold_v_q[l] && !(xfer && xfer_idx == LW'(l)));
      end
      if (xfer) found_wr_q <= found_inc(found_wr_q);
      if (fpop) found_rd_q <= found_inc(found_rd_q);
      found_cnt_q      <= found_cnt_q + (FW+1)'(xfer) - (FW+1)'(fpop);
      found_overflow_q <= !start_acc && (found_overflow_q || hit_drop);
      err_spurious_q   <= !start_acc && (err_spurious_q || spur != '0);
      hash_q           <= start_acc ? '0 : hash_d[48] ? '1 : hash_d[47:0];
    end
  end

  // Tag and found-nonce storage; contents are qualified by the counters so need no reset
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      if (push[l]) tag_mem_q[l][tag_wr_q[l]] <= base[31:0] + 32'(l);
    if (xfer) found_mem_q[found_wr_q] <= xfer_n;
  end

  assign bus.busy           = state_q != IDLE;
  assign bus.done           = done_q;
  assign bus.lane_valid     = lane_valid_q;
  assign bus.lane_nonce     = lane_nonce_q;
  assign bus.found_valid    = found_cnt_q != '0;
  assign bus.found_nonce    = found_cnt_q != '0 ? found_mem_q[found_rd_q] : '0;
  assign bus.found_overflow = found_overflow_q;
  assign bus.err_spurious   = err_spurious_q;
  assign bus.hash_count     = hash_q;
endmodule

// File: tb/tb_miner_dispatch.sv
// tb_miner_dispatch: directed scenarios for the nonce dispatcher
module tb_miner_dispatch;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  miner_dispatch_if #(.LANES(4)) bus ();

  miner_dispatch #(
    .LANES(4), .ISSUE_INTERVAL(8), .INFLIGHT(2), .FOUND_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] e);
    bus.nonce_start = s;
    bus.nonce_end = e;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.lane_valid !== 4'h0 || bus.lane_nonce !== 128'h0) begin bad++; $display("FAIL reset_lane: got %h/%h want 0/0", bus.lane_valid, bus.lane_nonce); end
    total++; if (bus.found_valid !== 1'b0 || bus.found_nonce !== 32'h0) begin bad++; $display("FAIL reset_found: got %b/%h want 0/0", bus.found_valid, bus.found_nonce); end
    total++; if (bus.hash_count !== 48'h0 || bus.err_spurious !== 1'b0 || bus.found_overflow !== 1'b0) begin bad++; $display("FAIL reset_status: got hash=%h err=%b ovf=%b want 0", bus.hash_count, bus.err_spurious, bus.found_overflow); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    go(32'h10, 32'h17);
    total++; if (bus.lane_valid !== 4'hF || bus.lane_nonce !== {32'h13, 32'h12, 32'h11, 32'h10}) begin bad++; $display("FAIL basic_round1: got %h/%h want f/00000013000000120000001100000010", bus.lane_valid, bus.lane_nonce); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    for (int i = 1; i < 8; i++) begin
      tick();
      total++; if (bus.lane_valid !== 4'h0) begin bad++; $display("FAIL basic_gap%0d: got %h want 0", i, bus.lane_valid); end
    end
    tick();
    total++; if (bus.lane_valid !== 4'hF || bus.lane_nonce !== {32'h17, 32'h16, 32'h15, 32'h14}) begin bad++; $display("FAIL basic_round2: got %h/%h want f/00000017000000160000001500000014", bus.lane_valid, bus.lane_nonce); end
    bus.res_valid = 4'hF;
    tick(2);
    bus.res_valid = 4'h0;
    total++; if (bus.hash_count !== 48'd8) begin bad++; $display("FAIL basic_hash: got %0d want 8", bus.hash_count); end
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL basic_predone: got done=%b busy=%b want 0/1", bus.done, bus.busy); end
    wait_done(5, cyc);
    total++; if (bus.done !== 1'b1 || cyc !== 1) begin bad++; $display("FAIL basic_done: got done=%b after %0d want 1 after 1", bus.done, cyc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall: got %b want 0", bus.busy); end
    tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_top_range();
    int cyc;
    go(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    total++; if (bus.lane_valid !== 4'b0011) begin bad++; $display("FAIL top_valid: got %b want 0011", bus.lane_valid); end
    total++; if (bus.lane_nonce[63:0] !== {32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin bad++; $display("FAIL top_nonce: got %h want fffffffffffffffe", bus.lane_nonce[63:0]); end
    tick();
    total++; if (bus.lane_valid !== 4'h0) begin bad++; $display("FAIL top_nowrap: got %h want 0", bus.lane_valid); end
    bus.res_valid = 4'b0011;
    tick();
    bus.res_valid = 4'h0;
    wait_done(5, cyc);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL top_done: got %b want 1", bus.done); end
    total++; if (bus.hash_count !== 48'd2 || bus.err_spurious !== 1'b0) begin bad++; $display("FAIL top_hash: got %0d err=%b want 2 err=0", bus.hash_count, bus.err_spurious); end
  endtask

  task automatic test_found_order();
    int cyc;
    bus.found_ready = 1'b1;
    go(32'h20, 32'h23);
    tick();
    bus.res_valid = 4'hF;
    bus.res_hit = 4'hF;
    tick();
    bus.res_valid = 4'h0;
    bus.res_hit = 4'h0;
    total++; if (bus.found_valid !== 1'b0) begin bad++; $display("FAIL found_early: got %b want 0", bus.found_valid); end
    tick();
    total++; if (bus.found_valid !== 1'b1 || bus.found_nonce !== 32'h20) begin bad++; $display("FAIL found_head0: got %b/%h want 1/00000020", bus.found_valid, bus.found_nonce); end
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (bus.found_valid !== 1'b1 || bus.found_nonce !== 32'h20 + 32'(i)) begin bad++; $display("FAIL found_head%0d: got %b/%h want 1/%h", i, bus.found_valid, bus.found_nonce, 32'h20 + 32'(i)); end
    end
    tick();
    total++; if (bus.found_valid !== 1'b0) begin bad++; $display("FAIL found_empty: got %b want 0", bus.found_valid); end
    total++; if (bus.found_overflow !== 1'b0) begin bad++; $display("FAIL found_ovf: got %b want 0", bus.found_overflow); end
    wait_done(5, cyc);
    total++; if (bus.done !== 1'b1 || bus.hash_count !== 48'd4) begin bad++; $display("FAIL found_done: got done=%b hash=%0d want 1/4", bus.done, bus.hash_count); end
  endtask

  task automatic test_overflow();
    bus.found_ready = 1'b0;
    go(32'h30, 32'h3B);
    tick(8);
    total++; if (bus.lane_valid !== 4'hF || bus.lane_nonce[31:0] !== 32'h34) begin bad++; $display("FAIL ovf_round2: got %h/%h want f/00000034", bus.lane_valid, bus.lane_nonce[31:0]); end
    bus.res_valid = 4'hF;
    bus.res_hit = 4'hF;
    tick();
    bus.res_valid = 4'h0;
    bus.res_hit = 4'h0;
    tick(4);
    total++; if (bus.found_valid !== 1'b1 || bus.found_nonce !== 32'h30 || bus.found_overflow !== 1'b0) begin bad++; $display("FAIL ovf_full: got %b/%h ovf=%b want 1/00000030 ovf=0", bus.found_valid, bus.found_nonce, bus.found_overflow); end
    tick(3);
    total++; if (bus.lane_valid !== 4'hF || bus.lane_nonce[31:0] !== 32'h38) begin bad++; $display("FAIL ovf_round3: got %h/%h want f/00000038", bus.lane_valid, bus.lane_nonce[31:0]); end
    bus.res_valid = 4'h1;
    bus.res_hit = 4'h1;
    tick();
    total++; if (bus.found_overflow !== 1'b0 || bus.found_nonce !== 32'h30) begin bad++; $display("FAIL ovf_held: got ovf=%b head=%h want 0/00000030", bus.found_overflow, bus.found_nonce); end
    tick();
    bus.res_valid = 4'h0;
    bus.res_hit = 4'h0;
    total++; if (bus.found_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bus.found_overflow); end
    total++; if (bus.hash_count !== 48'd6) begin bad++; $display("FAIL ovf_hash6: got %0d want 6", bus.hash_count); end
    bus.found_ready = 1'b1;
    bus.res_valid = 4'hE;
    for (int i = 1; i < 5; i++) begin
      tick();
      if (i == 2) bus.res_valid = 4'h0;
      total++; if (bus.found_valid !== 1'b1 || bus.found_nonce !== 32'h30 + 32'(i)) begin bad++; $display("FAIL ovf_pop%0d: got %b/%h want 1/%h", i, bus.found_valid, bus.found_nonce, 32'h30 + 32'(i)); end
    end
    tick();
    total++; if (bus.found_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL ovf_drained: got valid=%b busy=%b want 0/0", bus.found_valid, bus.busy); end
    total++; if (bus.hash_count !== 48'd12 || bus.found_overflow !== 1'b1) begin bad++; $display("FAIL ovf_final: got hash=%0d ovf=%b want 12/1", bus.hash_count, bus.found_overflow); end
  endtask

  task automatic test_stall();
    int cyc;
    go(32'h40, 32'h4B);
    tick(8);
    total++; if (bus.lane_valid !== 4'hF || bus.lane_nonce[31:0] !== 32'h44) begin bad++; $display("FAIL stall_round2: got %h/%h want f/00000044", bus.lane_valid, bus.lane_nonce[31:0]); end
    for (int i = 0; i < 12; i++) begin
      tick();
      total++; if (bus.lane_valid !== 4'h0) begin bad++; $display("FAIL stall_hold%0d: got %h want 0", i, bus.lane_valid); end
    end
    bus.res_valid = 4'hF;
    tick();
    total++; if (bus.lane_valid !== 4'hF || bus.lane_nonce !== {32'h4B, 32'h4A, 32'h49, 32'h48}) begin bad++; $display("FAIL stall_release: got %h/%h want f/0000004b0000004a0000004900000048", bus.lane_valid, bus.lane_nonce); end
    tick(2);
    bus.res_valid = 4'h0;
    wait_done(5, cyc);
    total++; if (bus.done !== 1'b1 || bus.hash_count !== 48'd12) begin bad++; $display("FAIL stall_done: got done=%b hash=%0d want 1/12", bus.done, bus.hash_count); end
  endtask

  task automatic test_invalid_range();
    go(32'h10, 32'h0F);
    total++; if (bus.lane_valid !== 4'h0 || bus.busy !== 1'b1) begin bad++; $display("FAIL inv_issue: got valid=%h busy=%b want 0/1", bus.lane_valid, bus.busy); end
    tick();
    total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL inv_done: got done=%b busy=%b want 1/0", bus.done, bus.busy); end
  endtask

  task automatic test_abort_reset();
    go(32'h50, 32'h6F);
    tick(7);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    total++; if (bus.lane_valid !== 4'h0 || bus.busy !== 1'b1) begin bad++; $display("FAIL abort_round: got valid=%h busy=%b want 0/1", bus.lane_valid, bus.busy); end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (bus.lane_valid !== 4'h0) begin bad++; $display("FAIL abort_quiet%0d: got %h want 0", i, bus.lane_valid); end
    end
    reset = 1'b0;
    tick();
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lane_valid !== 4'h0 || bus.lane_nonce !== 128'h0) begin bad++; $display("FAIL rst_ctrl: got busy=%b done=%b valid=%h want 0", bus.busy, bus.done, bus.lane_valid); end
    total++; if (bus.found_valid !== 1'b0 || bus.hash_count !== 48'h0 || bus.err_spurious !== 1'b0 || bus.found_overflow !== 1'b0) begin bad++; $display("FAIL rst_status: got fv=%b hash=%0d err=%b ovf=%b want 0", bus.found_valid, bus.hash_count, bus.err_spurious, bus.found_overflow); end
    reset = 1'b1;
    bus.res_valid = 4'h1;
    tick();
    bus.res_valid = 4'h0;
    total++; if (bus.err_spurious !== 1'b1 || bus.hash_count !== 48'h0) begin bad++; $display("FAIL spurious: got err=%b hash=%0d want 1/0", bus.err_spurious, bus.hash_count); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.nonce_start = '0;
    bus.nonce_end = '0;
    bus.res_valid = '0;
    bus.res_hit = '0;
    bus.found_ready = 1'b1;
    test_reset();
    test_basic();
    test_top_range();
    test_found_order();
    test_overflow();
    test_stall();
    test_invalid_range();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/miner_dispatch.md
# miner_dispatch

Multi-lane nonce dispatcher and result collector for the Odo/Keccak mining datapath. It hands nonces from a programmable inclusive range to `LANES` worker pipelines every `ISSUE_INTERVAL` cycles. It tracks in-flight nonces per lane so each returned pass/fail result can be matched to its nonce. Winning nonces are queued in a found-FIFO for the host probe logic, and a completed-hash count is kept.

## Interface
- `LANES`, 4: number of worker lanes (1–16)
- `ISSUE_INTERVAL`, 1000: cycles between issue rounds (≥ `LANES`, ≥ 2)
- `INFLIGHT`, 8: per-lane tag FIFO depth (power of 2)
- `FOUND_DEPTH`, 4: found-FIFO depth (power of 2)
- `clk`  in  1  clock
- `reset`  in  1  reset; one clock; reset is synchronous and active-low
- `start`  in  1  pulse; accepted only in IDLE; latches range
- `abort`  in  1  pulse; stops further issue
- `nonce_start`  in  32  first nonce
- `nonce_end`  in  32  last nonce, inclusive
- `busy`  out  1  high in RUN or DRAIN
- `done`  out  1  one-cycle pulse on DRAIN→IDLE
- `lane_valid`  out  LANES  per-lane one-cycle issue strobe
- `lane_nonce`  out  32*LANES  lane l nonce at bits [32l+31:32l], valid with strobe
- `res_valid`  in  LANES  per-lane result strobe, in issue order
- `res_hit`  in  LANES  result passed target; qualified by `res_valid`
- `found_valid`  out  1  found-FIFO non-empty (show-ahead)
- `found_nonce`  out  32  head of found-FIFO
- `found_ready`  in  1  pop when `found_valid`
- `found_overflow`  out  1  sticky; a hit was dropped
- `err_spurious`  out  1  sticky; `res_valid` on lane with empty tag FIFO
- `hash_count`  out  48  total results received, saturating

## Operation
- States are IDLE, RUN and DRAIN. Reset (`reset`=0 at a clock edge) sets IDLE and clears every output, counter, FIFO and sticky flag.
- IDLE→RUN happens on `start`. It latches `next` = `nonce_start` and `end` = `nonce_end`, zeroes the interval counter and clears `found_overflow`, `err_spurious` and `hash_count`. The found-FIFO is not cleared.
- If `nonce_end` < `nonce_start`, IDLE→DRAIN occurs directly and nothing is issued.
- Issue round in RUN: when the interval counter = 0, lane l strobes if `next`+l ≤ `end`, using 33-bit arithmetic. No wrap is permitted; `end` = 0xFFFFFFFF terminates cleanly. The strobed lane also pushes its nonce into its tag FIFO.
- After an issue round, `next` += `LANES` (33-bit). The counter then runs 1..`ISSUE_INTERVAL`-1 and returns to 0.
- Stall: if any lane that would strobe has a full tag FIFO, the whole round is held. The counter stays at 0 and no lane strobes until all of them have room.
- RUN→DRAIN happens after the round that issued `end`, or on `abort`. `abort` in the same cycle as a round suppresses that round.
- DRAIN→IDLE happens when all tag FIFOs are empty and all hit-hold registers are empty. `done` pulses on that transition.
- Results are processed in every state. `res_valid[l]` pops tag FIFO l, and `hash_count` adds popcount(`res_valid`).
- If `res_hit[l]` is set, the popped nonce loads hit-hold register l. If that register is already occupied, the hit is dropped and `found_overflow` is set.
- An empty tag FIFO on `res_valid` sets `err_spurious` and discards the result (no pop, no count).
- Hold-to-FIFO transfer: at most one per cycle, lowest occupied lane first. It occurs only when the found-FIFO is not full, or is being popped that same cycle.
- `start` or `abort` outside its valid state is ignored.

## Timing
- `start` sampled at cycle t: the first round has `lane_valid` high at t+1, and subsequent rounds at t+1+k·`ISSUE_INTERVAL` when not stalled.
- `lane_nonce` is registered and stable while its strobe is high. Its value is don't-care otherwise.
- A hit sampled at cycle t is in its hold register at t+1. Its nonce is at the found-FIFO head with `found_valid`=1 no earlier than t+2.
- Pop takes effect at the edge where `found_valid`&`found_ready`; the next head appears the following cycle.
- `busy` rises at t+1 after `start` and falls in the same cycle `done` pulses.
- Reset mid-operation drops all in-flight tags. Later worker results then raise `err_spurious`, which is expected.

## Test plan
- LANES=4, ISSUE_INTERVAL=8, range 0x10..0x17 → two rounds, 8 cycles apart: {0x10..0x13}, then {0x14..0x17}. Then DRAIN, then `done` after the 8th result. `hash_count`=8.
- Range 0xFFFFFFFE..0xFFFFFFFF, LANES=4 → one round: lanes 0–1 strobe, lanes 2–3 idle. There is no wrap, and `done` follows 2 results.
- All 4 lanes return a hit in the same cycle for nonces 0x20..0x23 → found-FIFO outputs 0x20, 0x21, 0x22, 0x23 in order, one per cycle. `found_overflow`=0.
- `found_ready`=0 with 5 hits over time, FOUND_DEPTH=4 → 4 nonces queued, the 5th is held, and the next hit on that lane sets `found_overflow`.
- Workers withhold results with INFLIGHT=2 → the 3rd round stalls and `lane_valid` stays 0. The round issues one cycle after the first result frees space.
- `abort` mid-RUN and `reset`=0 mid-DRAIN → no further strobes, and all outputs read 0 the cycle after reset. A stray `res_valid` then sets `err_spurious`.
